// File: rtl/syscall_pkg.sv
// Shared definitions for the SYSCALL controller: service codes, output kinds,
// FSM states and the decoded-service payload.
package syscall_pkg;

  // Supported service codes held in $v0
  localparam int unsigned SYS_PRINT_INT  = 1;
  localparam int unsigned SYS_EXIT       = 10;
  localparam int unsigned SYS_PRINT_CHAR = 11;
  localparam int unsigned SYS_EXIT2      = 17;
  localparam int unsigned SYS_PRINT_HEX  = 34;

  localparam int unsigned KIND_W = 2;

  // How the output sink should render out_data
  typedef enum logic [KIND_W-1:0] {
    KIND_INT  = 2'b00,
    KIND_CHAR = 2'b01,
    KIND_HEX  = 2'b10
  } out_kind_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2,
    ST_SKIP = 2'd3
  } state_e;

  // Decoded view of one service code
  typedef struct packed {
    logic      is_print;
    logic      is_exit;
    logic      exit_arg;  // exit code comes from a0 rather than 0
    out_kind_e kind;
    logic      bad;
  } code_info_t;

endpackage

// File: rtl/syscall_code_decode.sv
// Combinational service-code decoder.
// Ports: v0 (service code) -> info_c {is_print, is_exit, exit_arg, kind, bad}.
module syscall_code_decode
  import syscall_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] v0,
  output code_info_t        info_c
);

  // Classify the code; anything not listed is unsupported
  always_comb begin
    info_c      = '0;
    info_c.kind = KIND_INT;
    case (v0)
      DATA_W'(SYS_PRINT_INT): begin
        info_c.is_print = 1'b1;
        info_c.kind     = KIND_INT;
      end
      DATA_W'(SYS_PRINT_CHAR): begin
        info_c.is_print = 1'b1;
        info_c.kind     = KIND_CHAR;
      end
      DATA_W'(SYS_PRINT_HEX): begin
        info_c.is_print = 1'b1;
        info_c.kind     = KIND_HEX;
      end
      DATA_W'(SYS_EXIT): begin
        info_c.is_exit = 1'b1;
      end
      DATA_W'(SYS_EXIT2): begin
        info_c.is_exit  = 1'b1;
        info_c.exit_arg = 1'b1;
      end
      default: begin
        info_c.bad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/syscall_controller.sv
// SYSCALL sequencer for the single-cycle MIPS core. Stalls the PC while a
// print request handshakes with the output sink, halts on exit services until
// a resume pulse, and counts/flags accepted syscalls.
// Ports:
//   clk, rst (async, active-high)
//   syscall_valid, v0, a0      : syscall presented by the decoder
//   resume                     : pulse to leave HALT
//   out_ready                  : sink accepts out_data
//   pc_stall                   : combinational PC/regfile hold
//   halted, out_valid, out_kind, out_data, exit_code, bad_syscall,
//   syscall_count              : registered status / print payload
module syscall_controller
  import syscall_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              syscall_valid,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  input  logic              resume,
  input  logic              out_ready,
  output logic              pc_stall,
  output logic              halted,
  output logic              out_valid,
  output logic [KIND_W-1:0] out_kind,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] exit_code,
  output logic              bad_syscall,
  output logic [CNT_W-1:0]  syscall_count
);

  state_e     state_q, state_d;
  code_info_t dec_c;
  logic       stall_c;
  logic       accept_c;
  logic       load_print_c;
  logic       load_exit_c;
  logic       set_bad_c;
  logic       print_done_c;
  logic       leave_halt_c;

  syscall_code_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .v0     (v0),
    .info_c (dec_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_d      = state_q;
    stall_c      = 1'b0;
    accept_c     = 1'b0;
    load_print_c = 1'b0;
    load_exit_c  = 1'b0;
    set_bad_c    = 1'b0;
    print_done_c = 1'b0;
    leave_halt_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (syscall_valid) begin
          accept_c = 1'b1;
          if (dec_c.is_print) begin
            stall_c      = 1'b1;
            load_print_c = 1'b1;
            state_d      = ST_WAIT;
          end else if (dec_c.is_exit) begin
            stall_c     = 1'b1;
            load_exit_c = 1'b1;
            state_d     = ST_HALT;
          end else begin
            set_bad_c = 1'b1;  // retires as a NOP
          end
        end
      end
      ST_WAIT: begin
        // PC advances on the same edge the sink takes the data
        stall_c = ~out_ready;
        if (out_ready) begin
          print_done_c = 1'b1;
          state_d      = ST_RUN;
        end
      end
      ST_HALT: begin
        stall_c = 1'b1;
        if (resume) begin
          leave_halt_c = 1'b1;
          state_d      = ST_SKIP;
        end
      end
      ST_SKIP: begin
        // One unstalled cycle lets the exit SYSCALL retire without re-triggering
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Stall is forced low while reset is held, regardless of the inputs
  assign pc_stall = stall_c & ~rst;

  // Print request handshake and payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_kind  <= '0;
      out_data  <= '0;
    end else begin
      if (load_print_c) begin
        out_valid <= 1'b1;
        out_kind  <= dec_c.kind;
        out_data  <= a0;
      end else if (print_done_c) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Halt flag and exit code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted    <= 1'b0;
      exit_code <= '0;
    end else begin
      if (load_exit_c) begin
        halted    <= 1'b1;
        exit_code <= dec_c.exit_arg ? a0 : '0;
      end else if (leave_halt_c) begin
        halted <= 1'b0;
      end
    end
  end

  // Sticky bad-code flag and wrapping acceptance counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_syscall   <= 1'b0;
      syscall_count <= '0;
    end else begin
      if (set_bad_c) bad_syscall <= 1'b1;
      if (accept_c)  syscall_count <= syscall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_syscall_controller.sv
// Randomized scoreboard bench for syscall_controller. The driver behaves like
// the core (holds each SYSCALL until it retires) and queues expected prints and
// exit codes; a monitor compares them whenever the DUT presents them.
module tb_syscall_controller;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              syscall_valid;
  logic [DATA_W-1:0] v0;
  logic [DATA_W-1:0] a0;
  logic              resume;
  logic              out_ready;
  logic              pc_stall;
  logic              halted;
  logic              out_valid;
  logic [1:0]        out_kind;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] exit_code;
  logic              bad_syscall;
  logic [CNT_W-1:0]  syscall_count;

  syscall_controller #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .syscall_valid (syscall_valid),
    .v0            (v0),
    .a0            (a0),
    .resume        (resume),
    .out_ready     (out_ready),
    .pc_stall      (pc_stall),
    .halted        (halted),
    .out_valid     (out_valid),
    .out_kind      (out_kind),
    .out_data      (out_data),
    .exit_code     (exit_code),
    .bad_syscall   (bad_syscall),
    .syscall_count (syscall_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [33:0] print_q[$];  // {kind, data}
  logic [31:0] exit_q[$];
  int unsigned issued  = 0;
  logic        bad_exp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Service class: 0..2 print (value is the kind), 3 exit, 4 exit2, 5 unsupported
  function automatic int svc(input logic [31:0] code);
    case (code)
      32'd1:   return 0;
      32'd11:  return 1;
      32'd34:  return 2;
      32'd10:  return 3;
      32'd17:  return 4;
      default: return 5;
    endcase
  endfunction

  // Monitor: prints and exit codes are compared as the DUT presents them
  initial begin
    logic halted_prev;
    logic [33:0] e;
    halted_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        halted_prev = 1'b0;
      end else begin
        if (out_valid) begin
          check("print_expected", 64'(print_q.size() != 0), 64'(1));
          if (print_q.size() != 0) begin
            e = print_q[0];
            check("out_kind", 64'(out_kind), 64'(e[33:32]));
            check("out_data", 64'(out_data), 64'(e[31:0]));
            if (out_ready) void'(print_q.pop_front());
          end
        end
        if (halted && !halted_prev) begin
          check("exit_expected", 64'(exit_q.size() != 0), 64'(1));
          if (exit_q.size() != 0) check("exit_code", 64'(exit_code), 64'(exit_q.pop_front()));
        end
        halted_prev = halted;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_cycle();
    @(negedge clk);
    syscall_valid = 1'b0;
    v0            = $urandom;
    a0            = $urandom;
    resume        = 1'($urandom_range(0, 1));
    out_ready     = 1'($urandom_range(0, 1));
    #1 check("idle_stall", 64'(pc_stall), 64'(0));
  endtask

  // Print: one stall for the issue cycle plus one per not-ready WAIT cycle
  task automatic finish_print(input int w);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      v0        = $urandom;
      resume    = 1'($urandom_range(0, 1));
      #1 check("wait_stall", 64'(pc_stall), 64'(1));
      check("wait_valid", 64'(out_valid), 64'(1));
    end
    @(negedge clk);
    out_ready = 1'b1;
    v0        = $urandom;
    resume    = 1'($urandom_range(0, 1));
    #1 check("handshake_stall", 64'(pc_stall), 64'(0));
  endtask

  // Exit: stalled and halted until resume, then exactly one unstalled cycle
  task automatic finish_exit(input logic [31:0] code, input int h);
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      resume    = 1'b0;
      #1 check("halt_stall", 64'(pc_stall), 64'(1));
      check("halted", 64'(halted), 64'(1));
    end
    @(negedge clk);
    resume = 1'b1;
    #1 check("resume_stall", 64'(pc_stall), 64'(1));
    @(negedge clk);
    resume = 1'b0;
    v0     = code;
    #1 check("skip_stall", 64'(pc_stall), 64'(0));
    check("skip_halted", 64'(halted), 64'(0));
  endtask

  task automatic final_checks();
    @(posedge clk);
    #1;
    check("count", 64'(syscall_count), 64'(CNT_W'(issued)));
    check("bad_syscall", 64'(bad_syscall), 64'(bad_exp));
    check("valid_after", 64'(out_valid), 64'(0));
    check("halted_after", 64'(halted), 64'(0));
  endtask

  task automatic do_syscall(input logic [31:0] code, input logic [31:0] arg, input int w, input int h);
    int s;
    s = svc(code);
    @(negedge clk);
    syscall_valid = 1'b1;
    v0            = code;
    a0            = arg;
    resume        = 1'b0;
    out_ready     = 1'($urandom_range(0, 1));
    issued++;
    if (s < 3)       print_q.push_back({2'(s), arg});
    else if (s == 3) exit_q.push_back(32'd0);
    else if (s == 4) exit_q.push_back(arg);
    else             bad_exp = 1'b1;
    #1 check("issue_stall", 64'(pc_stall), 64'(s < 5));
    if (s < 3)      finish_print(w);
    else if (s < 5) finish_exit(code, h);
    final_checks();
  endtask

  initial begin
    logic [31:0] c;
    // Reset with an exit SYSCALL already presented
    rst = 1'b1; syscall_valid = 1'b1; v0 = 32'd10; a0 = $urandom;
    resume = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 64'(pc_stall), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_kind", 64'(out_kind), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_exit", 64'(exit_code), 64'(0));
    check("rst_bad", 64'(bad_syscall), 64'(0));
    check("rst_count", 64'(syscall_count), 64'(0));
    rst = 1'b0;
    issued = 1;
    exit_q.push_back(32'd0);
    #1 check("release_stall", 64'(pc_stall), 64'(1));
    finish_exit(32'd10, 5);
    final_checks();

    // Directed services
    do_syscall(32'd1, 32'hDEADBEEF, 3, 0);
    do_syscall(32'd11, 32'h00000141, 0, 0);
    do_syscall(32'd34, $urandom, 0, 0);
    do_syscall(32'd17, 32'hCAFEBABE, 0, 20);
    do_syscall(32'd5, $urandom, 0, 0);
    repeat (4) idle_cycle();
    check("bad_sticky", 64'(bad_syscall), 64'(1));
    check("resume_in_run", 64'(halted), 64'(0));
    do_syscall(32'd10, $urandom, 1, 2);

    // Random program
    repeat (150) begin
      case ($urandom_range(0, 6))
        0:       c = 32'd1;
        1:       c = 32'd11;
        2:       c = 32'd34;
        3:       c = 32'd10;
        4:       c = 32'd17;
        default: begin
          c = $urandom;
          if (svc(c) != 5) c = 32'd5;
        end
      endcase
      do_syscall(c, $urandom, $urandom_range(0, 3), $urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    // Back-to-back unsupported codes carry the counter past its wrap point
    repeat (300) do_syscall(32'd5 + 32'($urandom_range(0, 3)), $urandom, 0, 0);

    // Reset in the middle of a print handshake
    @(negedge clk);
    syscall_valid = 1'b1; v0 = 32'd1; a0 = $urandom; out_ready = 1'b0;
    print_q.push_back({2'b00, a0});
    @(negedge clk);
    out_ready = 1'b0;
    #1 check("midwait_valid", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_drop_valid", 64'(out_valid), 64'(0));
    check("rst_drop_count", 64'(syscall_count), 64'(0));
    check("rst_drop_stall", 64'(pc_stall), 64'(0));
    print_q.delete();
    issued  = 0;
    bad_exp = 1'b0;
    @(negedge clk);
    syscall_valid = 1'b0;
    #1 rst = 1'b0;
    do_syscall(32'd1, $urandom, 1, 0);

    repeat (3) idle_cycle();
    check("print_q_empty", 64'(print_q.size()), 64'(0));
    check("exit_q_empty", 64'(exit_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
